bcd_timer_ctrl: RTL and testbench
=================================

Name: bcd_timer_ctrl

Overview:
Run/pause/clear controller and sequencer for a cascaded chain of decimal (BCD) digit counters.
- Owns the prescaler that paces counting.
- Owns the decimal carry/borrow ripple between digits, preset loading and terminal-count detection.
- Sits between user controls (buttons/CPU strobes) and the digit display/compare logic; replaces free-running single-digit counters where start/stop timing is needed.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8).
PRESCALE, 10, clk cycles per count step (>=1); 1 means every clk cycle in RUN is a step.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  level, sampled each clk: begin/resume counting.
pause  input  1  level: suspend counting, keep value.
clear  input  1  level: return to IDLE, zero the value.
load  input  1  level: copy preset into the count value.
dir  input  1  0 = count up, 1 = count down; captured on start.
preset  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
bcd  output  4*DIGITS  current count value, BCD, registered.
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
busy  output  1  high while state==RUN.
tick  output  1  one-cycle pulse in the cycle bcd takes a stepped value.
done  output  1  one-cycle pulse in the first cycle state==DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, bcd=0, prescaler=0, dir_q=0, tick=0, done=0, busy=0. Reset mid-RUN aborts immediately; no done pulse.
- Terminal value T: all digits 9 when dir_q=0; all digits 0 when dir_q=1.
- Command priority per cycle: clear > load > pause > start. Exception: in PAUSE, start beats pause when both are high.
- clear (any state): next state=IDLE, bcd=0, prescaler=0, no tick/done.
- load (IDLE/PAUSE/DONE only; ignored in RUN):
  - bcd <= preset, each digit >9 saturates to 9.
  - prescaler=0.
  - State is unchanged, except DONE -> IDLE.
- start (IDLE/PAUSE/DONE): captures dir_q <= dir.
  - If bcd == T for the new dir: go to DONE and pulse done next cycle; no tick.
  - Otherwise go to RUN. From IDLE/DONE, prescaler=0. From PAUSE, prescaler keeps its value (resume mid-period).
  - start while in RUN is ignored.
- pause (RUN only): RUN -> PAUSE. The prescaler and bcd freeze that cycle, and no step is taken in that cycle even if the prescaler is at terminal.
- RUN stepping:
  - The prescaler counts 0..PRESCALE-1.
  - When it equals PRESCALE-1 it wraps to 0 and a step occurs.
  - Step up: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit (ripple, same cycle).
  - Step down: digit 0 -1. A digit at 0 becomes 9 and borrows from the next digit.
  - No wrap of the full value ever occurs, because terminal detection stops the count first.
- Stepped value: bcd updates on the step edge, with tick=1 for that one cycle.
- Reaching T: if the stepped value equals T, the same edge sets state=DONE and done=1 for one cycle (coincident with that tick). busy drops in that cycle.
- DONE: bcd holds, prescaler=0. Only clear/load/start act.
- Outputs: all registered, no combinational path from inputs to outputs. Inputs are synchronous to clk; no internal debouncing or edge detection, since commands are levels evaluated each cycle.

Test Plan:
1. DIGITS=2, PRESCALE=2. Load preset 0x97, dir=0, start 1 cycle: bcd 0x97 -> 0x98 (2 cycles) -> 0x99 (2 more cycles), tick on each step, done pulse with final tick, state=3, busy=0.
2. Carry/borrow ripple. DIGITS=3, PRESCALE=1, up from 0x099: next bcd=0x100. Load 0x100, dir=1, start: next bcd=0x099, then 0x098.
3. Pause/resume. PRESCALE=4. Pause one cycle before a step: bcd holds across a 10-cycle pause, no tick. Start: step occurs exactly 1 cycle after resume (prescaler preserved).
4. Priority and ignore rules:
   - clear+load+start in RUN -> IDLE, bcd=0.
   - load in RUN ignored, bcd keeps counting.
   - start+pause in PAUSE -> RUN.
   - preset digit 0xC loads as 9.
5. Immediate terminal. Load 0x00, dir=1, start -> DONE with done pulse next cycle, no tick, bcd stays 0x00. Then dir=0, start -> RUN, first step gives 0x01.
6. Async reset. Assert rst mid-RUN between clk edges: bcd=0, state=IDLE, busy=0 immediately, no done/tick. After release, counting resumes only on a new start.

Source files
------------

// File: rtl/bcd_timer_ctrl_if.sv
// Command and status bundle between a controlling agent and bcd_timer_ctrl.
// The master drives the command levels and the preset; the slave returns the count and status.
interface bcd_timer_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  pause;
    logic                  clear;
    logic                  load;
    logic                  dir;
    logic [4*DIGITS-1:0]   preset;
    logic [4*DIGITS-1:0]   bcd;
    logic [1:0]            state;
    logic                  busy;
    logic                  tick;
    logic                  done;

    modport master (
        output start, pause, clear, load, dir, preset,
        input  bcd, state, busy, tick, done
    );

    modport slave (
        input  start, pause, clear, load, dir, preset,
        output bcd, state, busy, tick, done
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Run/pause/clear sequencer for a cascaded BCD digit counter with a prescaler,
// decimal carry/borrow ripple, saturating preset load and terminal-count detection.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_timer_ctrl_if.slave       bus
);
    localparam int              W         = 4 * DIGITS;
    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bcd_q, bcd_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            dir_q, dir_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    bcd_up, bcd_dn, bcd_step, preset_sat;
    logic [W-1:0]    term_run, term_start;
    logic [DIGITS-1:0] carry, borrow;
    logic            load_act, start_act, step_en, hit_step, hit_start;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Per-digit increment/decrement with ripple carry/borrow, plus preset saturation.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [3:0] p;
            assign d = bcd_q[4*gi +: 4];
            assign p = bus.preset[4*gi +: 4];
            assign bcd_up[4*gi +: 4] = !carry[gi]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign bcd_dn[4*gi +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign preset_sat[4*gi +: 4] = (p > 4'd9) ? 4'd9 : p;
            if (gi < DIGITS - 1) begin : g_chain
                assign carry[gi+1]  = carry[gi]  & (d == 4'd9);
                assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
            end
        end
    endgenerate

    assign bcd_step   = dir_q ? bcd_dn : bcd_up;
    assign term_run   = dir_q ? '0 : ALL_NINES;
    assign term_start = bus.dir ? '0 : ALL_NINES;

    // Command decode already folds in priority: clear > load > pause > start.
    assign load_act  = !bus.clear && bus.load && (state_q != S_RUN);
    assign start_act = !bus.clear && !load_act && bus.start && (state_q != S_RUN);
    assign step_en   = !bus.clear && !bus.pause && (state_q == S_RUN) && (pre_q == PRE_LAST);
    assign hit_step  = step_en && (bcd_step == term_run);
    assign hit_start = start_act && (bcd_q == term_start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            pre_q   <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            pre_q   <= pre_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        pre_d   = pre_q;
        dir_d   = dir_q;
        if (bus.clear) begin
            state_d = S_IDLE;
            bcd_d   = '0;
            pre_d   = '0;
        end else if (load_act) begin
            bcd_d = preset_sat;
            pre_d = '0;
            if (state_q == S_DONE) state_d = S_IDLE;
        end else if (start_act) begin
            dir_d = bus.dir;
            if (hit_start) begin
                state_d = S_DONE;
                pre_d   = '0;
            end else begin
                state_d = S_RUN;
                // Resuming from PAUSE keeps the partial prescaler period.
                if (state_q != S_PAUSE) pre_d = '0;
            end
        end else if (state_q == S_RUN) begin
            if (bus.pause) begin
                state_d = S_PAUSE;
            end else if (step_en) begin
                pre_d = '0;
                bcd_d = bcd_step;
                if (hit_step) state_d = S_DONE;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_comb begin
        tick_d = step_en;
        done_d = hit_step || hit_start;
        busy_d = (state_d == S_RUN);
    end

    assign bus.bcd   = bcd_q;
    assign bus.state = state_q;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl (3 digits, prescale 3) with an integer-valued reference
// model feeding a scoreboard queue, plus hand-derived spot checks.
module tb_bcd_timer_ctrl;
    localparam int D  = 3;
    localparam int PS = 3;
    localparam int W  = 4 * D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_timer_ctrl_if #(.DIGITS(D)) bus ();
    bcd_timer_ctrl #(.DIGITS(D), .PRESCALE(PS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    int m_st, m_val, m_pre, m_dir, m_tick, m_done;

    function automatic int term(int d);
        return (d != 0) ? 0 : (10 ** D) - 1;
    endfunction

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_val(logic [W-1:0] p);
        int acc, mul, dg;
        acc = 0;
        mul = 1;
        for (int i = 0; i < D; i++) begin
            dg = int'(p[4*i +: 4]);
            if (dg > 9) dg = 9;
            acc = acc + dg * mul;
            mul = mul * 10;
        end
        return acc;
    endfunction

    function automatic logic [16:0] obs_vec();
        return {bus.state, bus.busy, bus.tick, bus.done, bus.bcd};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {2'(m_st), 1'(m_st == 1), 1'(m_tick), 1'(m_done), to_bcd(m_val)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_val = 0; m_pre = 0; m_dir = 0; m_tick = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_tick = 0;
        m_done = 0;
        if (bus.clear) begin
            m_st = 0; m_val = 0; m_pre = 0;
        end else if (bus.load && m_st != 1) begin
            m_val = sat_val(bus.preset);
            m_pre = 0;
            if (m_st == 3) m_st = 0;
        end else if (m_st == 1) begin
            if (bus.pause) begin
                m_st = 2;
            end else if (m_pre == PS - 1) begin
                m_pre  = 0;
                m_val  = (m_dir != 0) ? m_val - 1 : m_val + 1;
                m_tick = 1;
                if (m_val == term(m_dir)) begin
                    m_st = 3; m_done = 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end else if (bus.start) begin
            m_dir = int'(bus.dir);
            if (m_val == term(m_dir)) begin
                m_st = 3; m_done = 1; m_pre = 0;
            end else begin
                if (m_st != 2) m_pre = 0;
                m_st = 1;
            end
        end
    endtask

    task automatic drv(bit s, bit p, bit c, bit l, bit d, logic [W-1:0] pr);
        bus.start = s; bus.pause = p; bus.clear = c; bus.load = l; bus.dir = d; bus.preset = pr;
    endtask

    task automatic cyc(string tag);
        logic [16:0] e;
        model_step();
        exp_q.push_back(exp_vec());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        assert (obs_vec() === e)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_vec(), e);
        end
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_vec++;
        assert (o === e)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, '0);
        model_reset();
        #12;
        chk("reset_state", 32'(obs_vec()), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Count up into all-nines
        drv(0, 0, 0, 1, 0, 12'h997); cyc("t1_load");
        drv(1, 0, 0, 0, 0, '0);      cyc("t1_start");
        drv(0, 0, 0, 0, 0, '0);      run(6, "t1_run");
        chk("t1_bcd", 32'(bus.bcd), 32'h999);
        chk("t1_state", 32'(bus.state), 32'd3);
        chk("t1_done_tick", {30'd0, bus.done, bus.tick}, 32'h3);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        cyc("t1_hold");
        chk("t1_done_clr", 32'(bus.done), 32'd0);

        // Carry and borrow ripple
        drv(0, 0, 0, 1, 0, 12'h099); cyc("t2_load");
        drv(1, 0, 0, 0, 0, '0);      cyc("t2_start");
        drv(0, 0, 0, 0, 0, '0);      run(3, "t2_up");
        chk("t2_carry", 32'(bus.bcd), 32'h100);
        drv(0, 0, 1, 0, 0, '0);      cyc("t2_clear");
        drv(0, 0, 0, 1, 0, 12'h100); cyc("t2_load_dn");
        drv(1, 0, 0, 0, 1, '0);      cyc("t2_start_dn");
        drv(0, 0, 0, 0, 0, '0);      run(3, "t2_dn");
        chk("t2_borrow", 32'(bus.bcd), 32'h099);
        run(3, "t2_dn2");
        chk("t2_dn2", 32'(bus.bcd), 32'h098);

        // Pause one cycle before a step, then resume mid-period
        drv(0, 0, 1, 0, 0, '0);      cyc("t3_clear");
        drv(1, 0, 0, 0, 0, '0);      cyc("t3_start");
        drv(0, 0, 0, 0, 0, '0);      run(2, "t3_run");
        drv(0, 1, 0, 0, 0, '0);      run(10, "t3_pause");
        chk("t3_paused", {18'd0, bus.state, bus.bcd}, {18'd0, 2'd2, 12'h000});
        drv(1, 0, 0, 0, 0, '0);      cyc("t3_resume");
        chk("t3_run_state", 32'(bus.state), 32'd1);
        drv(0, 0, 0, 0, 0, '0);      cyc("t3_step");
        chk("t3_step", {19'd0, bus.tick, bus.bcd}, {19'd0, 1'b1, 12'h001});

        // Priority and ignore rules
        drv(0, 0, 0, 1, 0, 12'h555); run(3, "t4_load_in_run");
        chk("t4_load_ignored", 32'(bus.bcd), 32'h002);
        drv(1, 0, 1, 1, 0, 12'h555); cyc("t4_clear_pri");
        chk("t4_clear_pri", {18'd0, bus.state, bus.bcd}, 32'h0);
        drv(0, 0, 0, 1, 0, 12'h0C5); cyc("t4_sat");
        chk("t4_sat", 32'(bus.bcd), 32'h095);
        drv(1, 0, 0, 0, 0, '0);      cyc("t4_start");
        drv(0, 1, 0, 0, 0, '0);      cyc("t4_pause");
        drv(1, 1, 0, 0, 0, '0);      cyc("t4_start_beats_pause");
        chk("t4_start_beats_pause", 32'(bus.state), 32'd1);

        // Immediate terminal on start, then count away from it
        drv(0, 0, 1, 0, 0, '0);      cyc("t5_clear");
        drv(0, 0, 0, 1, 0, 12'h000); cyc("t5_load");
        drv(1, 0, 0, 0, 1, '0);      cyc("t5_start_term");
        chk("t5_done", {17'd0, bus.state, bus.done, bus.tick, bus.bcd}, {17'd0, 2'd3, 1'b1, 1'b0, 12'h000});
        drv(1, 0, 0, 0, 0, '0);      cyc("t5_restart");
        chk("t5_restart", 32'(bus.state), 32'd1);
        drv(0, 0, 0, 0, 0, '0);      run(3, "t5_run");
        chk("t5_first_step", 32'(bus.bcd), 32'h001);

        // Asynchronous reset between edges while running
        run(1, "t6_run");
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_reset", 32'(obs_vec()), 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
        run(4, "t6_idle_after_reset");
        drv(1, 0, 0, 0, 0, '0);      cyc("t6_start");
        drv(0, 0, 0, 0, 0, '0);      run(3, "t6_run2");
        chk("t6_count", 32'(bus.bcd), 32'h001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
